// File: rtl/iconn_min_addr_arbiter.sv
// iconn_min_addr_arbiter: N-port smallest-address arbiter with round-robin tie-break and a registered valid/ready output stage
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   in_addr/in_valid    per-port request address and valid
//   in_ready            per-port accept, one-hot or zero
//   out_addr/out_port   registered winning address and port index
//   out_valid/out_ready registered output handshake
// Optional: define ICONN_MIN_ARB_AGE_EN to add per-port starvation counters saturating at AGE_LIMIT.
module iconn_min_addr_arbiter #(
   parameter int PORT_NUM        = 4,
   parameter int NODE_ADDR_WIDTH = 5,
   parameter int AGE_LIMIT       = 8
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic [NODE_ADDR_WIDTH-1:0]  in_addr [0:PORT_NUM-1],
   input  logic [PORT_NUM-1:0]         in_valid,
   output logic [PORT_NUM-1:0]         in_ready,
   output logic [NODE_ADDR_WIDTH-1:0]  out_addr,
   output logic [$clog2(PORT_NUM)-1:0] out_port,
   output logic                        out_valid,
   input  logic                        out_ready
);
   localparam int PW = $clog2(PORT_NUM);
   logic [PW-1:0]              rr_ptr;
   logic [PW-1:0]              min_win;
   logic [PW-1:0]              win;
   logic [PW-1:0]              p;
   logic [PW:0]                s;
   logic                       min_found;
   logic                       acc;
   logic [NODE_ADDR_WIDTH-1:0] min_addr;
`ifdef ICONN_MIN_ARB_AGE_EN
   localparam int AW = $clog2(AGE_LIMIT + 1);
   logic [AW-1:0] age [0:PORT_NUM-1];
   logic          urg_found;
   logic [PW-1:0] urg_win;
`endif

   // Ports are visited in circular order from rr_ptr; a strict '<' keeps the
   // first visited port among equal minimum addresses, giving the round-robin tie-break.
   always_comb begin
      min_win   = rr_ptr;
      min_found = 1'b0;
      min_addr  = '0;
      s         = '0;
      p         = '0;
`ifdef ICONN_MIN_ARB_AGE_EN
      urg_found = 1'b0;
      urg_win   = rr_ptr;
`endif
      for (int k = 0; k < PORT_NUM; k++) begin
         s = {1'b0, rr_ptr} + (PW+1)'(k);
         p = (s >= (PW+1)'(PORT_NUM)) ? PW'(s - (PW+1)'(PORT_NUM)) : PW'(s);
         if (in_valid[p] && (!min_found || in_addr[p] < min_addr)) begin
            min_found = 1'b1;
            min_addr  = in_addr[p];
            min_win   = p;
         end
`ifdef ICONN_MIN_ARB_AGE_EN
         if (!urg_found && in_valid[p] && age[p] == AW'(AGE_LIMIT)) begin
            urg_found = 1'b1;
            urg_win   = p;
         end
`endif
      end
`ifdef ICONN_MIN_ARB_AGE_EN
      win = urg_found ? urg_win : min_win;
`else
      win = min_win;
`endif
   end

   assign acc      = (|in_valid) & (!out_valid | out_ready);
   assign in_ready = acc ? (PORT_NUM'(1) << win) : '0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_addr  <= '0;
         out_port  <= '0;
         rr_ptr    <= '0;
      end else if (acc) begin
         out_valid <= 1'b1;
         out_addr  <= in_addr[win];
         out_port  <= win;
         rr_ptr    <= (win == PW'(PORT_NUM-1)) ? '0 : win + 1'b1;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

`ifdef ICONN_MIN_ARB_AGE_EN
   // A port ages only while it is requesting and loses an accepted arbitration.
   for (genvar g = 0; g < PORT_NUM; g++) begin : g_age
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n)
            age[g] <= '0;
         else
            age[g] <= (!in_valid[g] || (acc && win == PW'(g))) ? '0 :
                      (!acc || age[g] == AW'(AGE_LIMIT)) ? age[g] : age[g] + 1'b1;
      end
   end
`endif
endmodule

// File: tb/tb_iconn_min_addr_arbiter.sv
// tb_iconn_min_addr_arbiter: vector table, directed corner cases and randomized reference-model check of iconn_min_addr_arbiter
module tb_iconn_min_addr_arbiter;
   localparam int P  = 4;
   localparam int W  = 5;
   localparam int AL = 2;

   logic         clk = 1'b0;
   logic         rst_n;
   logic [W-1:0] in_addr [0:P-1];
   logic [P-1:0] in_valid, in_ready;
   logic [W-1:0] out_addr;
   logic [1:0]   out_port;
   logic         out_valid, out_ready;

   logic [W-1:0] a3 [0:2];
   logic [2:0]   v3, r3;
   logic [W-1:0] oa3;
   logic [1:0]   op3;
   logic         ov3, ordy3;

   iconn_min_addr_arbiter #(.PORT_NUM(P), .NODE_ADDR_WIDTH(W), .AGE_LIMIT(AL)) dut (
      .clk(clk), .rst_n(rst_n), .in_addr(in_addr), .in_valid(in_valid), .in_ready(in_ready),
      .out_addr(out_addr), .out_port(out_port), .out_valid(out_valid), .out_ready(out_ready));

   iconn_min_addr_arbiter #(.PORT_NUM(3), .NODE_ADDR_WIDTH(W), .AGE_LIMIT(AL)) dut3 (
      .clk(clk), .rst_n(rst_n), .in_addr(a3), .in_valid(v3), .in_ready(r3),
      .out_addr(oa3), .out_port(op3), .out_valid(ov3), .out_ready(ordy3));

   always #5 clk = ~clk;

   int vectors = 0;
   int miscompares = 0;

   typedef struct {
      logic [P-1:0] v;
      logic         ordy;
      logic [P-1:0] rdy;
      logic         ov;
      logic [W-1:0] oa;
      logic [1:0]   op;
   } tv_t;
   tv_t tv [8];

   // reference model state
   int m_rr, m_op, m_oa;
   bit m_ov;
   int m_age [P];

   task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0d expected %0d", n, act, exp);
      end
   endtask

   // Winner from the rules: urgent ports first (circular from rr), else the
   // minimum address, ties resolved by circular order from rr.
   function automatic int ref_winner();
      int best = 1 << W;
`ifdef ICONN_MIN_ARB_AGE_EN
      for (int k = 0; k < P; k++) begin
         int q = (m_rr + k) % P;
         if (in_valid[q] && m_age[q] == AL) return q;
      end
`endif
      for (int i = 0; i < P; i++)
         if (in_valid[i] && int'(in_addr[i]) < best) best = int'(in_addr[i]);
      for (int k = 0; k < P; k++) begin
         int q = (m_rr + k) % P;
         if (in_valid[q] && int'(in_addr[q]) == best) return q;
      end
      return -1;
   endfunction

   task automatic do_reset();
      in_valid = '0;
      v3 = '0;
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      m_rr = 0; m_op = 0; m_oa = 0; m_ov = 1'b0;
      for (int i = 0; i < P; i++) m_age[i] = 0;
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      int w, exp_p;
      bit acc, got;
      logic [P-1:0] exp_r, granted;
      rst_n = 1'b0;
      in_valid = '0;
      out_ready = 1'b1;
      in_addr = '{0, 0, 0, 0};
      a3 = '{0, 0, 0};
      v3 = '0;
      ordy3 = 1'b1;
      #1;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_addr", out_addr, 0);
      chk("rst_out_port", out_port, 0);
      chk("rst_in_ready", in_ready, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // vector table: addresses {9,3,7,3}
      tv[0] = '{4'b1111, 1'b1, 4'b0010, 1'b1, 5'd3, 2'd1};
      tv[1] = '{4'b1101, 1'b1, 4'b1000, 1'b1, 5'd3, 2'd3};
      tv[2] = '{4'b0101, 1'b1, 4'b0100, 1'b1, 5'd7, 2'd2};
      tv[3] = '{4'b0001, 1'b1, 4'b0001, 1'b1, 5'd9, 2'd0};
      tv[4] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 5'd9, 2'd0};
      tv[5] = '{4'b0100, 1'b0, 4'b0100, 1'b1, 5'd7, 2'd2};
      tv[6] = '{4'b0001, 1'b0, 4'b0000, 1'b1, 5'd7, 2'd2};
      tv[7] = '{4'b0001, 1'b1, 4'b0001, 1'b1, 5'd9, 2'd0};
      in_addr = '{9, 3, 7, 3};
      for (int i = 0; i < 8; i++) begin
         in_valid = tv[i].v;
         out_ready = tv[i].ordy;
         @(negedge clk);
         chk($sformatf("tv%0d_in_ready", i), in_ready, tv[i].rdy);
         @(posedge clk);
         #1;
         chk($sformatf("tv%0d_out_valid", i), out_valid, tv[i].ov);
         chk($sformatf("tv%0d_out_addr", i), out_addr, tv[i].oa);
         chk($sformatf("tv%0d_out_port", i), out_port, tv[i].op);
      end

      // equal addresses held: round-robin 0,1,2,3,0
      do_reset();
      in_addr = '{5, 5, 5, 5};
      in_valid = 4'b1111;
      out_ready = 1'b1;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         chk("tie_in_ready", in_ready, 4'b0001 << (k % 4));
         @(posedge clk);
         #1;
         chk("tie_out_port", out_port, k % 4);
         chk("tie_out_valid", out_valid, 1);
      end

      // backpressure for 5 cycles, then release with no bubble
      out_ready = 1'b0;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         chk("bp_in_ready", in_ready, 0);
         @(posedge clk);
         #1;
         chk("bp_out_valid", out_valid, 1);
         chk("bp_out_port", out_port, 0);
         chk("bp_out_addr", out_addr, 5);
      end
      out_ready = 1'b1;
      @(negedge clk);
      chk("bp_release_in_ready", in_ready, 4'b0010);
      @(posedge clk);
      #1;
      chk("bp_release_out_valid", out_valid, 1);
      chk("bp_release_out_port", out_port, 1);

      // asynchronous reset while holding a transfer
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("async_rst_out_valid", out_valid, 0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("post_rst_in_ready", in_ready, 4'b0001);
      @(posedge clk);
      #1;
      chk("post_rst_out_port", out_port, 0);
      chk("post_rst_out_valid", out_valid, 1);

      // three-port instance: rr_ptr wraps 2->0, ports 1 and 2 alternate
      do_reset();
      a3 = '{4, 4, 4};
      v3 = 3'b110;
      for (int k = 0; k < 4; k++) begin
         exp_p = (k % 2 == 0) ? 1 : 2;
         @(negedge clk);
         chk("p3_in_ready", r3, 3'b001 << exp_p);
         @(posedge clk);
         #1;
         chk("p3_out_port", op3, exp_p);
         chk("p3_out_valid", ov3, 1);
      end
      v3 = '0;

`ifdef ICONN_MIN_ARB_AGE_EN
      // aged port 0 at address 31 must win by its 3rd accept cycle
      do_reset();
      in_addr = '{31, 0, 0, 0};
      in_valid = 4'b1111;
      out_ready = 1'b1;
      got = 1'b0;
      for (int k = 0; k < 3; k++) begin
         if (!got) begin
            @(negedge clk);
            got = in_ready[0];
            @(posedge clk);
            #1;
         end
      end
      chk("age_port0_granted", got, 1);
`endif

      // randomized traffic against the reference model
      do_reset();
      granted = '0;
      for (int c = 0; c < 400; c++) begin
         for (int i = 0; i < P; i++) begin
            if (!in_valid[i] || granted[i]) begin
               in_valid[i] = ($urandom_range(0, 9) < 7);
               in_addr[i] = ($urandom_range(0, 1) == 1) ? W'($urandom_range(0, 3)) : W'($urandom_range(0, 31));
            end
         end
         out_ready = ($urandom_range(0, 3) != 0);
         @(negedge clk);
         w = ref_winner();
         acc = (w >= 0) && (!m_ov || out_ready);
         exp_r = acc ? (4'b0001 << w) : 4'b0000;
         chk("rnd_in_ready", in_ready, exp_r);
         granted = exp_r;
         for (int i = 0; i < P; i++) begin
            if (!in_valid[i]) m_age[i] = 0;
            else if (acc) m_age[i] = (i == w) ? 0 : ((m_age[i] < AL) ? m_age[i] + 1 : AL);
         end
         if (acc) begin
            m_ov = 1'b1;
            m_oa = int'(in_addr[w]);
            m_op = w;
            m_rr = (w + 1) % P;
         end else if (out_ready) begin
            m_ov = 1'b0;
         end
         @(posedge clk);
         #1;
         chk("rnd_out_valid", out_valid, m_ov);
         chk("rnd_out_addr", out_addr, m_oa);
         chk("rnd_out_port", out_port, m_op);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/iconn_min_addr_arbiter.md
Name: iconn_min_addr_arbiter

Overview:
N-port generalisation of the interconnect's smallest-address priority selection, for routers whose node fan-in exceeds two.
- Each cycle, among all valid requesters, grants the one with the smallest node address.
- Breaks equal-address ties round-robin.
- Moves the winner through a registered valid/ready output stage.
- Sits between the per-port input buffers and the downstream link of an iconn router node.

Parameters:
PORT_NUM, 4, number of requesting ports; legal range is 2 or more
NODE_ADDR_WIDTH, 5, width of the node address in bits
AGE_LIMIT, 8, starvation threshold in lost grants; used only when ICONN_MIN_ARB_AGE_EN is defined; legal range is 1 or more

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous reset, active-low
in_addr  input  NODE_ADDR_WIDTH x [0:PORT_NUM-1]  per-port node address (unpacked array)
in_valid  input  PORT_NUM  per-port request valid
in_ready  output  PORT_NUM  per-port grant/accept; one-hot or zero
out_addr  output  NODE_ADDR_WIDTH  registered winning address
out_port  output  $clog2(PORT_NUM)  registered winning port index
out_valid  output  1  output stage holds a transfer
out_ready  input  1  downstream accepts out_*

Behaviour:
- Reset (rst_n low, asynchronous): out_valid=0, out_addr=0, out_port=0, rr_ptr=0, all age counters=0. in_ready is combinational and is 0 while out_valid=0 and no input is valid.
- Candidate set: ports with in_valid=1.
- Winner: the candidate with the minimum in_addr, compared unsigned.
- Tie-break among equal minimum addresses: the first matching port in circular order starting at rr_ptr (rr_ptr, rr_ptr+1, ... wrapping at PORT_NUM).
- accept = (any in_valid) & (!out_valid | out_ready).
- in_ready[winner] = accept; all other in_ready bits = 0. in_ready never asserts for a port with in_valid=0.
- On accept, at the next clk edge:
  - out_addr <= in_addr[winner]
  - out_port <= winner
  - out_valid <= 1
  - rr_ptr <= (winner+1) mod PORT_NUM; the wrap is explicit, so PORT_NUM need not be a power of two.
- No accept and out_ready=1: out_valid <= 0. out_addr and out_port hold their values.
- Output stall (out_valid=1, out_ready=0): out_* hold, all in_ready=0.
- Throughput: 1 transfer/cycle with continuous out_ready. Latency: 1 cycle from in_valid&in_ready to out_valid.
- Simultaneous drain and refill in one cycle (out_valid=1, out_ready=1, an input valid): the new winner loads with no bubble.
- Input protocol: an input holds in_valid and in_addr stable until its in_ready. The block does not check this protocol.
- Single valid port: that port wins regardless of its address or rr_ptr.
- Reset asserted mid-transfer: the output transfer is lost, out_valid drops immediately, and rr_ptr returns to 0.

Optional Feature:
Macro: ICONN_MIN_ARB_AGE_EN.
- Defined, each port i has a counter age[i] of $clog2(AGE_LIMIT+1) bits:
  - Increments, saturating at AGE_LIMIT, on any accept where in_valid[i]=1 and i is not the winner.
  - Clears when port i wins or when in_valid[i]=0.
  - Ports with age==AGE_LIMIT are urgent. When any urgent port exists, the winner is the first urgent port in circular order from rr_ptr, ignoring address.
  - This bounds the wait of any held request to at most AGE_LIMIT+PORT_NUM-1 grants.
- Undefined:
  - No counters exist.
  - Selection is pure minimum-address with the round-robin tie-break.
  - A port holding a large address can starve indefinitely.

Test Plan:
- Reset, then in_valid=4'b1111 with addr {9,3,7,3}, out_ready=1:
  - Cycle 1: in_ready=4'b0010; next cycle out_addr=3, out_port=1.
  - Cycle 2: in_ready=4'b1000 (rr_ptr=2); out_port=3.
  - Then port 2 (addr 7), then port 0 (addr 9).
- Ties: all four ports valid with addr=5 held continuously, out_ready=1 -> grants in order 0,1,2,3,0 on consecutive cycles.
- Backpressure: out_ready=0 with out_valid=1 -> out_* are stable and in_ready=0 for 5 cycles. Raise out_ready -> a new load occurs in the same cycle; no bubble.
- PORT_NUM=3: ports 1 and 2 valid with equal addr, ports granted in a loop -> rr_ptr wraps 2->0 and ports alternate 1,2.
- With ICONN_MIN_ARB_AGE_EN and AGE_LIMIT=2: port 0 is held at addr 31 while ports 1–3 continuously present addr 0 -> port 0 is granted on or before its 3rd accept cycle.
- Assert rst_n low while out_valid=1 -> out_valid=0 with no clock edge; after release the first grant follows rr_ptr=0.
